// File: rtl/display_pkg.sv
// Shared types and defaults for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int DEFAULT_N_DIGITS = 8;
  localparam int DEFAULT_CHAR_W   = 5;

  typedef logic [DEFAULT_CHAR_W-1:0] char_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Phase counter: counts 0..LIMIT-1 while enabled, done flags the last count.
module tick_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + WIDTH'(1);
    end
  end

  assign done = en && (count == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blanking and a
// double-buffered frame that only swaps at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = DEFAULT_N_DIGITS,
  parameter int IDX_W        = $clog2(N_DIGITS),
  parameter int CHAR_W       = DEFAULT_CHAR_W,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [N_DIGITS*CHAR_W-1:0] frame_in,
  output logic [IDX_W-1:0]         digit_sel,
  output logic [N_DIGITS-1:0]      an,
  output logic [CHAR_W-1:0]        char_out,
  output logic                     frame_start,
  output scan_state_t              scan_state
);

  localparam int PH_MAX = max_int(PRESCALE, BLANK_CYCLES);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 2 || PRESCALE < 1 || BLANK_CYCLES < 1 || IDX_W != $clog2(N_DIGITS)) begin : g_bad_params
    $error("display_scan_ctrl: illegal parameter combination");
  end

  // Handshake: a frame transfers on any rising edge where load_valid and
  // load_ready are both high; load_ready is simply "shadow buffer empty".

  scan_state_t state, next_state;
  logic [IDX_W-1:0]           digit_next;
  logic                       boundary;
  logic                       blank_done, show_done, phase_clear;
  logic                       swap, xfer;
  logic                       shadow_full;
  logic [N_DIGITS*CHAR_W-1:0] shadow_buf, active_buf, active_next;
  logic [N_DIGITS-1:0]        an_next;
  logic [CHAR_W-1:0]          char_next;

  always_comb begin
    next_state = state;
    digit_next = digit_sel;
    boundary   = 1'b0;
    if (!enable) begin
      next_state = IDLE;
      digit_next = '0;
    end else begin
      case (state)
        IDLE: begin
          next_state = BLANK;
          digit_next = '0;
          boundary   = 1'b1;
        end
        BLANK: begin
          if (blank_done) next_state = SHOW;
        end
        SHOW: begin
          if (show_done) begin
            next_state = BLANK;
            if (digit_sel == LAST_DIGIT) begin
              digit_next = '0;
              boundary   = 1'b1;
            end else begin
              digit_next = digit_sel + IDX_W'(1);
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // A transfer and a swap never coincide: one needs the shadow empty, the other full.
  assign swap        = boundary && shadow_full;
  assign xfer        = load_valid && !shadow_full;
  assign active_next = swap ? shadow_buf : active_buf;
  assign phase_clear = reset || (next_state != state);

  // Outputs are registered from next-cycle values so char_out is already
  // valid on the first BLANK cycle of each digit.
  always_comb begin
    an_next   = '1;
    char_next = '0;
    if (next_state == SHOW) begin
      an_next = ~(N_DIGITS'(1) << digit_next);
    end
    if (next_state != IDLE) begin
      char_next = active_next[digit_next*CHAR_W +: CHAR_W];
    end
  end

  tick_counter #(.WIDTH(PH_W), .LIMIT(BLANK_CYCLES)) u_blank_ctr (
    .clk   (clk),
    .clear (phase_clear),
    .en    (state == BLANK),
    .done  (blank_done)
  );

  tick_counter #(.WIDTH(PH_W), .LIMIT(PRESCALE)) u_show_ctr (
    .clk   (clk),
    .clear (phase_clear),
    .en    (state == SHOW),
    .done  (show_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      digit_sel   <= '0;
      an          <= '1;
      char_out    <= '0;
      frame_start <= 1'b0;
      active_buf  <= '0;
      shadow_buf  <= '0;
      shadow_full <= 1'b0;
    end else begin
      state       <= next_state;
      digit_sel   <= digit_next;
      an          <= an_next;
      char_out    <= char_next;
      frame_start <= boundary;
      active_buf  <= active_next;
      if (xfer) begin
        shadow_buf  <= frame_in;
        shadow_full <= 1'b1;
      end else if (swap) begin
        shadow_full <= 1'b0;
      end
    end
  end

  assign load_ready = ~shadow_full;
  assign scan_state = state;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan controller for the multiplexed seven-segment name display. Sequences the digit index across `N_DIGITS` digits, and inserts a blanking interval before each digit to suppress ghosting. Drives the active-low anode vector and presents the current digit's character code to the downstream segment decoder. Accepts new frame text through a valid/ready handshake into a shadow buffer, which is swapped in only at frame boundaries so a frame is never shown torn.

## Interface
- `N_DIGITS`, 8, number of digits scanned; ≥2
- `IDX_W`, 3, digit index width; `$clog2(N_DIGITS)`
- `CHAR_W`, 5, character code width per digit
- `PRESCALE`, 100000, cycles each digit is lit (SHOW); ≥1
- `BLANK_CYCLES`, 16, cycles all anodes are off before each digit (BLANK); ≥1

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  run scanning; low forces IDLE
- `load_valid`  in  1  `frame_in` holds a new frame
- `load_ready`  out  1  shadow buffer empty, can accept a frame
- `frame_in`  in  N_DIGITS*CHAR_W  digit i at bits `[i*CHAR_W +: CHAR_W]`
- `digit_sel`  out  IDX_W  current digit index
- `an`  out  N_DIGITS  anode enables, active-low, one-cold in SHOW
- `char_out`  out  CHAR_W  active-buffer character for `digit_sel`
- `frame_start`  out  1  one-cycle pulse on entry to BLANK of digit 0

## Operation
- FSM states: IDLE, BLANK, SHOW.
  - IDLE → BLANK when `enable`=1. `digit_sel`=0 on entry, and `frame_start` pulses.
  - BLANK lasts exactly `BLANK_CYCLES` cycles, then goes to SHOW.
  - SHOW lasts exactly `PRESCALE` cycles, then goes to BLANK with `digit_sel` incremented.
  - Index wraps from `N_DIGITS-1` to 0. The wrap is a frame boundary and pulses `frame_start`.
  - Any state → IDLE on the cycle after `enable`=0. The phase counter clears and `digit_sel` returns to 0.
- Outputs by state:
  - `an` is all ones in IDLE and BLANK.
  - In SHOW, `an[digit_sel]`=0 and all other bits are 1.
- `char_out` = active_buf[`digit_sel`] in BLANK and SHOW, and 0 in IDLE. It is therefore stable throughout BLANK, before the anode turns on.
- Handshake:
  - `load_ready` = !shadow_full.
  - Transfer occurs when `load_valid && load_ready` at a rising edge: `frame_in` is copied to the shadow buffer and shadow_full is set.
  - `frame_in` is ignored when `load_ready`=0.
- Swap:
  - Happens on every transition into BLANK of digit 0, including IDLE → BLANK.
  - If shadow_full was set before that edge, active_buf takes the shadow buffer and shadow_full clears.
  - A transfer on the same edge as a boundary lands in the shadow buffer and is swapped at the next boundary.
- Phase counter width: `$clog2(max(PRESCALE, BLANK_CYCLES))`. It counts 0..limit-1 and clears on every state change.

## Timing
- Reset values: state IDLE, `an`='1, `digit_sel`=0, `char_out`=0, `frame_start`=0, `load_ready`=1, active_buf=0, shadow_full=0.
- All outputs are registered; there are no combinational input-to-output paths.
- From `enable` rising (sampled at edge k):
  - BLANK is entered at k+1, with `frame_start`=1 at k+1.
  - `an[0]`=0 first at k+1+`BLANK_CYCLES`.
- Digit period = `BLANK_CYCLES`+`PRESCALE`. Frame period = `N_DIGITS`*(`BLANK_CYCLES`+`PRESCALE`).
- `load_ready` falls the cycle after a transfer. It rises the cycle after the swap edge.
- Reset mid-frame returns to the reset values on the next edge. Shadow contents are discarded.
- `enable` toggling low then high restarts from digit 0 and performs a swap check.

## Structure
- Package `display_pkg` holds:
  - enum typedef `scan_state_t` {IDLE, BLANK, SHOW}
  - default `N_DIGITS` and `CHAR_W` constants
  - typedef `char_t` (logic [CHAR_W-1:0])
- One sub-module, `tick_counter`:
  - parameterised width and limit
  - synchronous `clear` and `en` inputs
  - `done` pulse at limit-1
  - Used for the BLANK/SHOW phase timing.
- Digit index, FSM, buffers and handshake live in `display_scan_ctrl`.

## Test plan
Bench parameters: `N_DIGITS`=4, `PRESCALE`=4, `BLANK_CYCLES`=2, `CHAR_W`=5.

- **Reset/IDLE:** reset 3 cycles with `enable`=0 → `an`=4'b1111, `digit_sel`=0, `char_out`=0, `load_ready`=1, with no `frame_start`.
- **Scan order:** `enable`=1 held → `frame_start` at cycle 1. `an` sequence is 1111×2, 1110×4, 1111×2, 1101×4, …, 0111×4. `frame_start` repeats every 24 cycles.
- **Load and swap:** load frame {3,2,1,0} → displayed digits 0..3 read 0,1,2,3 from the next boundary. `load_ready`=0 until that boundary, then returns to 1.
- **Boundary collision:** transfer on the exact edge of `frame_start` → old frame shown for one full frame, new frame appears at the following boundary.
- **Backpressure:** second `load_valid` while `load_ready`=0 with different data → ignored; the first frame is the one displayed.
- **Mid-operation disable/reset:**
  - `enable`=0 during SHOW of digit 2 → `an`=1111 and `digit_sel`=0 next cycle.
  - `reset` during BLANK with shadow_full=1 → all outputs at reset values and `load_ready`=1.
